// File: rtl/niu_sio_pkg.sv
// Shared types and field positions for the SIO->NIU response receiver.
package niu_sio_pkg;

  localparam int unsigned RSP_TYPE_HI = 127;
  localparam int unsigned RSP_TYPE_LO = 122;
  localparam int unsigned TAG_HI      = 79;
  localparam int unsigned TAG_LO      = 64;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned LANE_W      = 16;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned LANES       = DATA_W / LANE_W;

  typedef struct packed {
    logic [5:0]                rsp_type;
    logic [15:0]               tag;
    logic                      has_data;
    logic                      par_err;
    logic [BEATS*DATA_W-1:0]   data;
  } rsp_entry_t;

  typedef enum logic [0:0] {StIdle, StData} rcv_state_e;

  // Even parity per 16-bit lane.
  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [LANES-1:0] p;
    for (int i = 0; i < int'(LANES); i++) begin
      p[i] = ^d[i*LANE_W +: LANE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/niu_sio_rsp_fifo.sv
// Completed-response queue; a push at full is accepted only when a pop happens in the same cycle.
module niu_sio_rsp_fifo
  import niu_sio_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       push,
  input  rsp_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output rsp_entry_t head
);

  rsp_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q, count_d;
  logic                   push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: head is qualified by empty at the top level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/niu_sio_rsp_rcv.sv
// NIU-side receiver for SIO outbound responses: framing, beat assembly, parity, and queueing.
module niu_sio_rsp_rcv
  import niu_sio_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic                    iol2clk,
  input  logic                    rst_l,
  input  logic                    sio_niu_hdr_vld,
  input  logic                    sio_niu_datareq,
  input  logic [DATA_W-1:0]       sio_niu_data,
  input  logic [LANES-1:0]        sio_niu_parity,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [5:0]              rsp_type,
  output logic [15:0]             rsp_tag,
  output logic                    rsp_has_data,
  output logic [BEATS*DATA_W-1:0] rsp_data,
  output logic                    rsp_par_err,
  output logic                    proto_err,
  output logic                    ovf_err
);

  rcv_state_e                     state_q, state_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic [5:0]                     type_q, type_d;
  logic [15:0]                    tag_q, tag_d;
  logic [BEATS-2:0][DATA_W-1:0]   beat_q, beat_d;
  logic                           par_q, par_d;
  logic                           proto_q, proto_d;
  logic                           ovf_q, ovf_d;

  logic                           take_hdr, lane_bad, push, pop, full, empty;
  rsp_entry_t                     push_entry, head;

  assign lane_bad = |(sio_niu_parity ^ lane_parity(sio_niu_data));
  assign pop      = rsp_vld & rsp_rdy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    par_d      = par_q;
    proto_d    = proto_q;
    take_hdr   = 1'b0;
    push       = 1'b0;
    push_entry = '0;

    unique case (state_q)
      StIdle: begin
        take_hdr = sio_niu_hdr_vld;
        if (!sio_niu_hdr_vld && sio_niu_datareq) proto_d = 1'b1;
      end
      StData: begin
        if (sio_niu_hdr_vld) begin
          // Header mid-packet: drop the partial packet and restart framing.
          proto_d  = 1'b1;
          take_hdr = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == 2'd3) begin
          push                = 1'b1;
          push_entry.rsp_type = type_q;
          push_entry.tag      = tag_q;
          push_entry.has_data = 1'b1;
          push_entry.par_err  = par_q | lane_bad;
          push_entry.data     = {sio_niu_data, beat_q[2], beat_q[1], beat_q[0]};
          state_d             = StIdle;
        end else begin
          beat_d[cnt_q] = sio_niu_data;
          par_d         = par_q | lane_bad;
          cnt_d         = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_hdr) begin
      if (sio_niu_datareq) begin
        type_d  = sio_niu_data[RSP_TYPE_HI:RSP_TYPE_LO];
        tag_d   = sio_niu_data[TAG_HI:TAG_LO];
        cnt_d   = '0;
        par_d   = 1'b0;
        state_d = StData;
      end else begin
        push                = 1'b1;
        push_entry.rsp_type = sio_niu_data[RSP_TYPE_HI:RSP_TYPE_LO];
        push_entry.tag      = sio_niu_data[TAG_HI:TAG_LO];
        state_d             = StIdle;
      end
    end
  end

  assign ovf_d = ovf_q | (push & full & ~pop);

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      type_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      par_q   <= 1'b0;
      proto_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      par_q   <= par_d;
      proto_q <= proto_d;
      ovf_q   <= ovf_d;
    end
  end

  niu_sio_rsp_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (iol2clk),
    .rst_l      (rst_l),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  assign rsp_vld      = ~empty;
  assign rsp_type     = rsp_vld ? head.rsp_type : '0;
  assign rsp_tag      = rsp_vld ? head.tag      : '0;
  assign rsp_has_data = rsp_vld & head.has_data;
  assign rsp_data     = rsp_vld ? head.data     : '0;
  assign rsp_par_err  = rsp_vld & head.par_err;
  assign proto_err    = proto_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_niu_sio_rsp_rcv.sv
// Directed bench for niu_sio_rsp_rcv with hand-computed expectations.
module tb_niu_sio_rsp_rcv;

  logic         iol2clk = 1'b0;
  logic         rst_l;
  logic         sio_niu_hdr_vld;
  logic         sio_niu_datareq;
  logic [127:0] sio_niu_data;
  logic [7:0]   sio_niu_parity;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [5:0]   rsp_type;
  logic [15:0]  rsp_tag;
  logic         rsp_has_data;
  logic [511:0] rsp_data;
  logic         rsp_par_err;
  logic         proto_err;
  logic         ovf_err;

  int n_chk  = 0;
  int n_pass = 0;

  // Beat patterns: every lane of 0000/1111/2222/3333 holds an even number of ones -> parity 8'h00.
  logic [127:0] b0, b1, b2, b3;
  logic [511:0] exp_data;

  always #5 iol2clk = ~iol2clk;

  niu_sio_rsp_rcv #(
    .DEPTH (2),
    .PTR_W (1)
  ) dut (
    .iol2clk         (iol2clk),
    .rst_l           (rst_l),
    .sio_niu_hdr_vld (sio_niu_hdr_vld),
    .sio_niu_datareq (sio_niu_datareq),
    .sio_niu_data    (sio_niu_data),
    .sio_niu_parity  (sio_niu_parity),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_type        (rsp_type),
    .rsp_tag         (rsp_tag),
    .rsp_has_data    (rsp_has_data),
    .rsp_data        (rsp_data),
    .rsp_par_err     (rsp_par_err),
    .proto_err       (proto_err),
    .ovf_err         (ovf_err)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic idle_in();
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = '0;
    sio_niu_parity  = '0;
  endtask

  task automatic send_hdr(input logic [5:0] ty, input logic [15:0] tg, input logic dreq);
    sio_niu_hdr_vld          = 1'b1;
    sio_niu_datareq          = dreq;
    sio_niu_data             = '0;
    sio_niu_data[127:122]    = ty;
    sio_niu_data[79:64]      = tg;
    sio_niu_parity           = '0;
    step();
    idle_in();
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [7:0] par);
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = d;
    sio_niu_parity  = par;
    step();
    idle_in();
  endtask

  task automatic pop_one();
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    idle_in();
    rsp_rdy = 1'b0;
    step();
    step();
    rst_l = 1'b1;
  endtask

  initial begin
    b0 = '0;
    b1 = {8{16'h1111}};
    b2 = {8{16'h2222}};
    b3 = {8{16'h3333}};
    exp_data = {b3, b2, b1, b0};

    // Reset state.
    rst_l = 1'b0;
    rsp_rdy = 1'b0;
    idle_in();
    step();
    chk("rst_vld", rsp_vld, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_ovf", ovf_err, 0);
    step();
    rst_l = 1'b1;
    step();

    // 1: header-only.
    send_hdr(6'h2A, 16'h1234, 1'b0);
    chk("ho_vld", rsp_vld, 1);
    chk("ho_type", rsp_type, 6'h2A);
    chk("ho_tag", rsp_tag, 16'h1234);
    chk("ho_has_data", rsp_has_data, 0);
    chk("ho_data", rsp_data, 0);
    pop_one();
    chk("ho_popped", rsp_vld, 0);

    // 2: data response, good parity.
    send_hdr(6'h05, 16'h00F0, 1'b1);
    send_beat(b0, 8'h00);
    send_beat(b1, 8'h00);
    send_beat(b2, 8'h00);
    chk("d_vld_early", rsp_vld, 0);
    send_beat(b3, 8'h00);
    chk("d_vld", rsp_vld, 1);
    chk("d_type", rsp_type, 6'h05);
    chk("d_tag", rsp_tag, 16'h00F0);
    chk("d_has_data", rsp_has_data, 1);
    chk("d_data", rsp_data, exp_data);
    chk("d_par", rsp_par_err, 0);
    rsp_rdy = 1'b1;
    chk("d_stable", rsp_tag, 16'h00F0);
    pop_one();

    // 3: parity error on beat 2 lane 5.
    send_hdr(6'h05, 16'h00F1, 1'b1);
    send_beat(b0, 8'h00);
    send_beat(b1, 8'h00);
    send_beat(b2, 8'h20);
    send_beat(b3, 8'h00);
    chk("pe_vld", rsp_vld, 1);
    chk("pe_par", rsp_par_err, 1);
    chk("pe_data", rsp_data, exp_data);
    chk("pe_proto", proto_err, 0);
    pop_one();

    // 4a: overflow with rsp_rdy low.
    send_hdr(6'h01, 16'h00A1, 1'b0);
    send_hdr(6'h01, 16'h00A2, 1'b0);
    chk("of_no_ovf_yet", ovf_err, 0);
    send_hdr(6'h01, 16'h00A3, 1'b0);
    chk("of_ovf", ovf_err, 1);
    chk("of_head0", rsp_tag, 16'h00A1);
    pop_one();
    chk("of_head1", rsp_tag, 16'h00A2);
    pop_one();
    chk("of_empty", rsp_vld, 0);

    // 4b: push at full with simultaneous pop.
    do_reset();
    send_hdr(6'h01, 16'h00B1, 1'b0);
    send_hdr(6'h01, 16'h00B2, 1'b0);
    rsp_rdy = 1'b1;
    send_hdr(6'h01, 16'h00B3, 1'b0);
    rsp_rdy = 1'b0;
    chk("pp_ovf", ovf_err, 0);
    chk("pp_head0", rsp_tag, 16'h00B2);
    pop_one();
    chk("pp_head1", rsp_tag, 16'h00B3);
    pop_one();
    chk("pp_empty", rsp_vld, 0);

    // 5a: header arrives at beat 2.
    do_reset();
    send_hdr(6'h11, 16'h00C1, 1'b1);
    send_beat(b0, 8'h00);
    send_beat(b1, 8'h00);
    send_hdr(6'h22, 16'h00C2, 1'b0);
    chk("pa_proto", proto_err, 1);
    chk("pa_vld", rsp_vld, 1);
    chk("pa_type", rsp_type, 6'h22);
    chk("pa_tag", rsp_tag, 16'h00C2);
    chk("pa_has_data", rsp_has_data, 0);
    pop_one();
    step();
    step();
    chk("pa_no_partial", rsp_vld, 0);

    // 5b: isolated datareq.
    do_reset();
    sio_niu_datareq = 1'b1;
    step();
    idle_in();
    step();
    chk("iso_proto", proto_err, 1);
    chk("iso_vld", rsp_vld, 0);

    // 6: reset during beat 1 with one entry queued.
    do_reset();
    send_hdr(6'h01, 16'h00D1, 1'b0);
    send_hdr(6'h05, 16'h00D2, 1'b1);
    send_beat(b0, 8'h00);
    chk("rm_queued", rsp_vld, 1);
    rst_l = 1'b0;
    send_beat(b1, 8'h00);
    chk("rm_vld", rsp_vld, 0);
    chk("rm_proto", proto_err, 0);
    rst_l = 1'b1;
    step();
    send_hdr(6'h33, 16'h00D3, 1'b0);
    chk("rm_new_vld", rsp_vld, 1);
    chk("rm_new_tag", rsp_tag, 16'h00D3);
    chk("rm_new_has_data", rsp_has_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/niu_sio_rsp_rcv.md
Name: niu_sio_rsp_rcv

Overview:
- NIU-side receiver for the SIO->NIU outbound response interface: the direct consumer of sio_niu_hdr_vld / sio_niu_datareq / sio_niu_data / sio_niu_parity.
- Parses the header cycle and assembles the optional 4-beat 64-byte payload.
- Checks per-lane parity and queues completed responses for the NIU DMA engine through a valid/ready port.
- Flags protocol violations and buffer overflow, since SIO applies no backpressure.

Parameters:
- DEPTH, 2, number of completed-response entries buffered (power of 2, >=2).
- PTR_W, 1, log2(DEPTH).

Ports:
- iol2clk  in  1  IO L2 clock, single clock domain.
- rst_l  in  1  synchronous, active-low reset.
- sio_niu_hdr_vld  in  1  header cycle qualifier.
- sio_niu_datareq  in  1  with hdr_vld: 4 payload beats follow.
- sio_niu_data  in  128  header (header cycle) or payload beat.
- sio_niu_parity  in  8  parity, one bit per 16-bit lane.
- rsp_vld  out  1  head entry valid.
- rsp_rdy  in  1  consumer accepts head entry.
- rsp_type  out  6  header bits [127:122].
- rsp_tag  out  16  header bits [79:64].
- rsp_has_data  out  1  entry carries payload.
- rsp_data  out  512  beat0 in [127:0] ... beat3 in [511:384]; zero when no data.
- rsp_par_err  out  1  parity error on any beat of this entry.
- proto_err  out  1  sticky protocol error.
- ovf_err  out  1  sticky overflow; response dropped.

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; beat counter 0; sticky flags cleared. Reset mid-packet discards the partial packet and all queued entries.
- Framing:
  - Header cycle T has hdr_vld=1.
  - If datareq=1 at T, payload beats are the cycles T+1..T+4, one beat per cycle, no gaps.
  - If datareq=0 at T, the response is header-only (write ack).
- Parity: lane i is good when sio_niu_parity[i] == ^sio_niu_data[16i+15:16i] (even parity). Checked on payload beats only; any bad lane on any beat sets the entry's par_err.
- FSM IDLE:
  - hdr_vld & ~datareq -> push entry at the end of T (has_data=0, data=0); stay IDLE.
  - hdr_vld & datareq -> latch type/tag, go to DATA with cnt=0.
  - datareq & ~hdr_vld -> set proto_err; ignore.
- FSM DATA:
  - Each cycle store the beat into slot cnt and increment cnt.
  - At cnt==3, push the entry at the end of the cycle and go to IDLE.
  - hdr_vld during DATA -> set proto_err, abort the partial packet (no push), and treat the cycle as a new header per the IDLE rules.
- Latency, empty FIFO:
  - Header-only: rsp_vld=1 at T+1.
  - Data response: rsp_vld=1 at T+5.
- Output handshake: entry pops on rsp_vld & rsp_rdy. Outputs come straight from the head entry (registered storage) and stay stable while rsp_vld & ~rsp_rdy.
- Full FIFO:
  - A push with a simultaneous pop is accepted.
  - A push without a pop is dropped, sets ovf_err, and leaves the FIFO unchanged.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits.
- Sticky flags clear only on reset.

Decomposition:
- Package niu_sio_pkg:
  - Field constants: RSP_TYPE_HI=127, RSP_TYPE_LO=122, TAG_HI=79, TAG_LO=64.
  - BEATS=4, LANE_W=16.
  - rsp_entry_t: type, tag, has_data, par_err, data[511:0].
  - FSM state enum {IDLE, DATA}.
- One sub-module, niu_sio_rsp_fifo: synchronous DEPTH-entry FIFO of rsp_entry_t with push/pop/full/empty and simultaneous push-pop at full allowed.
- Framing FSM, beat assembler and parity check live in the top.

Test Plan:
1. Header-only: hdr_vld=1, datareq=0, data[127:122]=6'h2A, data[79:64]=16'h1234 at T -> rsp_vld at T+1, rsp_type=2A, rsp_tag=1234, has_data=0, rsp_data=0.
2. Data response with good parity: header tag 16'h00F0, then beats 128'h0..0, 128'h1..1, 128'h2..2, 128'h3..3 with correct parity -> rsp_vld at T+5, rsp_data={3..3,2..2,1..1,0..0}, par_err=0.
3. Parity error: same as test 2 but flip sio_niu_parity[5] on beat 2 -> entry delivered with rsp_par_err=1, data intact, no proto_err.
4. Overflow: rsp_rdy=0, send DEPTH+1 header-only responses -> first DEPTH queued in order, last dropped, ovf_err=1. Repeat with rsp_rdy=1 on the push cycle at full -> accepted, ovf_err stays 0.
5. Protocol errors: new hdr_vld at beat 2 of a data packet -> proto_err=1, partial packet discarded, new header processed normally. Isolated datareq with hdr_vld=0 -> proto_err=1, nothing pushed.
6. Reset mid-packet: rst_l=0 during beat 1 with 1 entry queued -> next cycle rsp_vld=0, FSM IDLE. A subsequent clean header-only response is delivered at T+1.
